data_ram_dbg: RTL

Parametrised single-port data memory for the accumulator CPU, with a post-reset clear engine and a streaming dump port. The dump port reads the whole array out over a valid/ready handshake for the debug/UART path. It replaces the fixed-size data memory on the CPU's RdRam/WrRam bus, keeping that bus's names and half-cycle read timing. Zero-initialisation moves from simulation-only init into hardware.

---
 rtl/data_ram_dbg_pkg.sv | 18 +
 rtl/data_ram_dbg_ram_sp_core.sv | 64 ++++++
 rtl/data_ram_dbg.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/data_ram_dbg_pkg.sv
// data_ram_dbg_pkg
//   Shared definitions for the data memory and its debug wrapper:
//   default bus widths shared with the CPU top and the controller
//   state encoding.
package data_ram_dbg_pkg;

   localparam int unsigned AB_DEFAULT = 11;
   localparam int unsigned DB_DEFAULT = 16;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_CLEAR     = 3'd1,
      S_DUMP_RD   = 3'd2,
      S_DUMP_HOLD = 3'd3,
      S_DONE      = 3'd4
   } state_e;

endpackage

// File: rtl/data_ram_dbg_ram_sp_core.sv
// ram_sp_core
//   Single-port DEPTH x DB array clocked on the falling edge. A write
//   has priority over a read at the same edge. Read data is registered
//   into one of two holding registers picked by rsel_i, so debug reads
//   never disturb the CPU read value. Out-of-range writes are dropped
//   and out-of-range reads return zero.
// Ports:
//   clk, rst       falling-edge clock, synchronous active-high reset
//   we_i, re_i     write / read enables
//   rsel_i         read destination: 0 = CPU register, 1 = debug register
//   addr_i         word address
//   wdata_i        write data
//   cpu_rdata_o    registered CPU read data
//   dbg_rdata_o    registered debug read data
module ram_sp_core #(
   parameter int unsigned AB    = 11,
   parameter int unsigned DB    = 16,
   parameter int unsigned DEPTH = 2**AB
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we_i,
   input  logic          re_i,
   input  logic          rsel_i,
   input  logic [AB-1:0] addr_i,
   input  logic [DB-1:0] wdata_i,
   output logic [DB-1:0] cpu_rdata_o,
   output logic [DB-1:0] dbg_rdata_o
);

   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AB:0] DEPTH_W = DEPTH[AB:0];

   logic [DB-1:0] mem_q [DEPTH];
   logic [DB-1:0] cpu_rdata_q, dbg_rdata_q;
   logic          in_range;
   logic [IW-1:0] idx;
   logic [DB-1:0] rd_word;

   always_comb begin
      in_range = ({1'b0, addr_i} < DEPTH_W);
      idx      = addr_i[IW-1:0];
      rd_word  = in_range ? mem_q[idx] : '0;
   end

   // The array itself is not reset; zeroing is done by the clear engine.
   always_ff @(negedge clk) begin
      if (we_i && in_range) mem_q[idx] <= wdata_i;
   end

   always_ff @(negedge clk) begin
      if (rst) begin
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else if (re_i && !we_i) begin
         if (rsel_i) dbg_rdata_q <= rd_word;
         else        cpu_rdata_q <= rd_word;
      end
   end

   assign cpu_rdata_o = cpu_rdata_q;
   assign dbg_rdata_o = dbg_rdata_q;

endmodule

// File: rtl/data_ram_dbg.sv
// data_ram_dbg
//   CPU data memory with a post-reset clear engine and a streaming dump
//   port. All state advances on the falling edge of clk, giving the CPU
//   half-cycle read timing on the RdRam/WrRam bus.
// Ports:
//   clk, rst        falling-edge clock, synchronous active-high reset
//   RdRam, WrRam    CPU read / write strobes (write wins)
//   Addr, In_Data   CPU word address and write data
//   Out_Data        registered CPU read data
//   Busy            high while in reset, clearing or dumping
//   dump_start      request a full-array dump (honoured in IDLE only)
//   dump_valid/ready, dump_addr, dump_data   dump beat handshake
//   dump_done       one-cycle pulse after the last beat is accepted
module data_ram_dbg
   import data_ram_dbg_pkg::*;
#(
   parameter int unsigned AB             = AB_DEFAULT,
   parameter int unsigned DB             = DB_DEFAULT,
   parameter int unsigned DEPTH          = 2**AB,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          RdRam,
   input  logic          WrRam,
   input  logic [AB-1:0] Addr,
   input  logic [DB-1:0] In_Data,
   output logic [DB-1:0] Out_Data,
   output logic          Busy,
   input  logic          dump_start,
   output logic          dump_valid,
   input  logic          dump_ready,
   output logic [AB-1:0] dump_addr,
   output logic [DB-1:0] dump_data,
   output logic          dump_done
);

   localparam int unsigned LAST_I   = DEPTH - 1;
   localparam logic [AB:0] LAST_PTR = LAST_I[AB:0];

   state_e        state_q;
   logic [AB:0]   ptr_q;           // one spare bit so DEPTH = 2**AB never wraps
   logic          dump_valid_q;
   logic [AB-1:0] dump_addr_q;
   logic          dump_done_q;

   logic          we_d, re_d, rsel_d;
   logic [AB-1:0] addr_d;
   logic [DB-1:0] wdata_d;

   // Address/data/enable source select: CPU in IDLE, engine otherwise.
   always_comb begin
      we_d    = 1'b0;
      re_d    = 1'b0;
      rsel_d  = 1'b0;
      addr_d  = Addr;
      wdata_d = In_Data;
      if (!rst) begin
         unique case (state_q)
            S_IDLE: begin
               we_d = WrRam;
               re_d = RdRam;
            end
            S_CLEAR: begin
               we_d    = 1'b1;
               addr_d  = ptr_q[AB-1:0];
               wdata_d = '0;
            end
            S_DUMP_RD: begin
               re_d   = 1'b1;
               rsel_d = 1'b1;
               addr_d = ptr_q[AB-1:0];
            end
            default: ;
         endcase
      end
   end

   always_ff @(negedge clk) begin
      if (rst) begin
         state_q      <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
         ptr_q        <= '0;
         dump_valid_q <= 1'b0;
         dump_addr_q  <= '0;
         dump_done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (dump_start) begin
                  state_q <= S_DUMP_RD;
                  ptr_q   <= '0;
               end
            end
            S_CLEAR: begin
               ptr_q <= ptr_q + 1'b1;
               if (ptr_q == LAST_PTR) state_q <= S_IDLE;
            end
            S_DUMP_RD: begin
               state_q      <= S_DUMP_HOLD;
               dump_valid_q <= 1'b1;
               dump_addr_q  <= ptr_q[AB-1:0];
            end
            S_DUMP_HOLD: begin
               if (dump_ready) begin
                  dump_valid_q <= 1'b0;
                  if (ptr_q == LAST_PTR) begin
                     state_q     <= S_DONE;
                     dump_done_q <= 1'b1;
                  end else begin
                     state_q <= S_DUMP_RD;
                     ptr_q   <= ptr_q + 1'b1;
                  end
               end
            end
            S_DONE: begin
               state_q     <= S_IDLE;
               dump_done_q <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   ram_sp_core #(
      .AB    (AB),
      .DB    (DB),
      .DEPTH (DEPTH)
   ) u_core (
      .clk         (clk),
      .rst         (rst),
      .we_i        (we_d),
      .re_i        (re_d),
      .rsel_i      (rsel_d),
      .addr_i      (addr_d),
      .wdata_i     (wdata_d),
      .cpu_rdata_o (Out_Data),
      .dbg_rdata_o (dump_data)
   );

   assign Busy       = rst || (state_q != S_IDLE);
   assign dump_valid = dump_valid_q;
   assign dump_addr  = dump_addr_q;
   assign dump_done  = dump_done_q;

endmodule
